// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential FP adder/subtractor.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  // guard, round and sticky bits carried below the significand
  localparam int GRS_W = 3;

  // Quiet NaN pattern {0, all-ones exponent, 1, 0...}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
// Latency: 0 cycles (purely combinational).
// Backpressure: n/a.
// Ports: val - vector to scan (MSB first); cnt - number of leading zeros.
module fp_lzc #(
  parameter  int WIDTH = 27,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] val,
  output logic [CNT_W-1:0] cnt
);

  // scan upward so the highest set bit is the last one to write cnt
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (val[i]) begin
        cnt = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// IEEE-754 add/subtract (RNE) as a one-stage-per-cycle FSM: IDLE-UNPACK-ALIGN-ADD-NORM-ROUND-DONE.
// Latency: out_valid rises 6 cycles after the accept edge, for every operand class.
// Backpressure: one op in flight; in_ready low from accept until the result is consumed, z/flags held meanwhile.
// Ports: clk, rst (async active-low), in_valid/in_ready/op/x/y request side,
//        out_valid/out_ready/z/flags result side, flags = {invalid, overflow, underflow, inexact}.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic [3:0]   flags
);

  localparam int MW  = MAN_W + 1 + GRS_W;  // aligned significand incl. G/R/S
  localparam int SW  = MW + 1;             // sum with carry
  localparam int EW1 = EXP_W + 1;          // exponent with overflow headroom
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  state_t state, state_nxt;

  logic [W-1:0]     x_q, y_q;
  logic             op_q;
  logic             special_q;   // result already final; later stages pass through
  logic             sx_q, sy_q;
  logic [EXP_W-1:0] ex_q, ey_q;
  logic [MAN_W:0]   mx_q, my_q;
  logic             sa_q, sub_q;
  logic [MW-1:0]    ma_q, mb_q, mant_q;
  logic [EW1-1:0]   e_q;
  logic [SW-1:0]    sum_q;
  logic [W-1:0]     z_q;
  flags_t           flags_q;
  logic             out_valid_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign flags     = flags_q;

  // ---------------- unpack ----------------
  logic [EXP_W-1:0] x_exp, y_exp;
  logic [MAN_W-1:0] x_frac, y_frac;
  logic             y_sign_eff, x_nan, y_nan, x_inf, y_inf;

  assign x_exp      = x_q[W-2:MAN_W];
  assign y_exp      = y_q[W-2:MAN_W];
  assign x_frac     = x_q[MAN_W-1:0];
  assign y_frac     = y_q[MAN_W-1:0];
  assign y_sign_eff = y_q[W-1] ^ op_q;
  assign x_nan      = (x_exp == EXP_ONES) && (x_frac != '0);
  assign y_nan      = (y_exp == EXP_ONES) && (y_frac != '0);
  assign x_inf      = (x_exp == EXP_ONES) && (x_frac == '0);
  assign y_inf      = (y_exp == EXP_ONES) && (y_frac == '0);

  // ---------------- align ----------------
  logic             x_ge;
  logic [EXP_W-1:0] ea, eb, d;
  logic [MAN_W:0]   ma, mb;
  logic [MW-1:0]    a_ext, b_ext, b_shift, b_mask, b_al;
  logic [31:0]      d32;

  always_comb begin
    x_ge    = {ex_q, mx_q} >= {ey_q, my_q};
    ea      = x_ge ? ex_q : ey_q;
    eb      = x_ge ? ey_q : ex_q;
    ma      = x_ge ? mx_q : my_q;
    mb      = x_ge ? my_q : mx_q;
    d       = ea - eb;
    d32     = 32'(d);
    a_ext   = {ma, {GRS_W{1'b0}}};
    b_ext   = {mb, {GRS_W{1'b0}}};
    b_shift = b_ext >> d32;
    b_mask  = ~({MW{1'b1}} << d32);
    if (d32 > 32'(MW - 1)) begin
      b_al = {{(MW-1){1'b0}}, |b_ext};
    end else begin
      b_al = {b_shift[MW-1:1], b_shift[0] | (|(b_ext & b_mask))};
    end
  end

  // ---------------- add ----------------
  logic [SW-1:0] sum;
  assign sum = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

  // ---------------- normalise ----------------
  logic [LZW-1:0] lz;
  logic [31:0]    lim32, sh32;
  logic [MW-1:0]  n_mant;
  logic [EW1-1:0] n_e;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .val (sum_q[MW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    // left shift may not take the exponent below 1; hitting the limit means subnormal
    lim32 = 32'(e_q) - 32'd1;
    sh32  = (32'(lz) < lim32) ? 32'(lz) : lim32;
    if (sum_q[SW-1]) begin
      n_mant = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      n_e    = e_q + EW1'(1);
    end else begin
      n_mant = sum_q[MW-1:0] << sh32;
      n_e    = e_q - EW1'(sh32);
      if (!n_mant[MW-1]) begin
        n_e = '0;
      end
    end
  end

  // ---------------- round ----------------
  logic             g, r, s, inc, inx, ovf;
  logic [MAN_W+1:0] rnd;
  logic [EW1-1:0]   e_r;
  logic [MAN_W-1:0] frac_r;

  always_comb begin
    g      = mant_q[2];
    r      = mant_q[1];
    s      = mant_q[0];
    inc    = g & (r | s | mant_q[GRS_W]);
    inx    = g | r | s;
    rnd    = {1'b0, mant_q[MW-1:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
    e_r    = e_q;
    frac_r = rnd[MAN_W-1:0];
    if (rnd[MAN_W+1]) begin
      e_r    = e_q + EW1'(1);
      frac_r = rnd[MAN_W:1];
    end else if ((e_q == '0) && rnd[MAN_W]) begin
      // subnormal rounded up into the smallest normal
      e_r = EW1'(1);
    end
    ovf = e_r >= {1'b0, EXP_ONES};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Special results still walk every stage so latency is the same for all inputs.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = UNPACK;
      UNPACK:  state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_valid_q && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= 1'b0;
      special_q   <= 1'b0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      ex_q        <= '0;
      ey_q        <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      sa_q        <= 1'b0;
      sub_q       <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      e_q         <= '0;
      sum_q       <= '0;
      mant_q      <= '0;
      z_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q       <= x;
            y_q       <= y;
            op_q      <= op;
            special_q <= 1'b0;
            flags_q   <= '0;
          end
        end
        UNPACK: begin
          sx_q <= x_q[W-1];
          sy_q <= y_sign_eff;
          ex_q <= (|x_exp) ? x_exp : EXP_W'(1);
          ey_q <= (|y_exp) ? y_exp : EXP_W'(1);
          mx_q <= {|x_exp, x_frac};
          my_q <= {|y_exp, y_frac};
          if (x_nan || y_nan || (x_inf && y_inf && (x_q[W-1] != y_sign_eff))) begin
            special_q       <= 1'b1;
            z_q             <= W'(qnan(EXP_W, MAN_W));
            flags_q.invalid <= 1'b1;
          end else if (x_inf) begin
            special_q <= 1'b1;
            z_q       <= {x_q[W-1], EXP_ONES, {MAN_W{1'b0}}};
          end else if (y_inf) begin
            special_q <= 1'b1;
            z_q       <= {y_sign_eff, EXP_ONES, {MAN_W{1'b0}}};
          end
        end
        ALIGN: begin
          ma_q  <= a_ext;
          mb_q  <= b_al;
          e_q   <= {1'b0, ea};
          sa_q  <= x_ge ? sx_q : sy_q;
          sub_q <= (sx_q != sy_q);
        end
        ADD: begin
          sum_q <= sum;
          if (!special_q && (sum == '0)) begin
            special_q <= 1'b1;
            z_q       <= '0;
          end
        end
        NORM: begin
          if (!special_q) begin
            mant_q <= n_mant;
            e_q    <= n_e;
          end
        end
        ROUND: begin
          if (!special_q) begin
            if (ovf) begin
              z_q              <= {sa_q, EXP_ONES, {MAN_W{1'b0}}};
              flags_q.overflow <= 1'b1;
              flags_q.inexact  <= 1'b1;
            end else begin
              z_q               <= {sa_q, e_r[EXP_W-1:0], frac_r};
              flags_q.inexact   <= inx;
              flags_q.underflow <= (e_r == '0) && inx;
            end
          end
        end
        DONE: begin
          out_valid_q <= !(out_valid_q && out_ready);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq (FP32 build).
// Latency: checks out_valid low at cycle 5 and high at cycle 6 after accept on every case.
// Backpressure: exercises result hold under out_ready=0 and reset during ALIGN.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INV  = 4'b1000;
  localparam logic [3:0] F_OVF  = 4'b0100;
  localparam logic [3:0] F_INX  = 4'b0001;

  always #5 clk = ~clk;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // wait (bounded) for idle, then drive one request at a negedge so it is accepted on the next posedge
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " idle"}, 64'(in_ready), 64'd1);
    x = a;
    y = b;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // scramble operands after accept: must not affect the result
    in_valid = 1'b0;
    x = 32'h1234_5678;
    y = 32'h8765_4321;
    op = ~o;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o,
                     input logic [31:0] ez, input logic [3:0] ef);
    issue(tag, a, b, o);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk({tag, " busy"}, 64'(in_ready), 64'd0);
      if (c == 5) chk({tag, " lat5"}, 64'(out_valid), 64'd0);
    end
    chk({tag, " lat6"}, 64'(out_valid), 64'd1);
    chk({tag, " z"}, 64'(z), 64'(ez));
    chk({tag, " flags"}, 64'(flags), 64'(ef));
    // consume; a request offered in the same cycle must be ignored
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " consumed"}, 64'(out_valid), 64'd0);
    chk({tag, " noaccept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit stable;
    logic [31:0] z0;
    logic [3:0]  f0;

    // reset state
    #2;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst z", 64'(z), 64'd0);
    chk("rst flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run("1+1",       32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, F_NONE);
    run("1-1",       32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, F_NONE);
    run("tie even",  32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, F_INX);
    run("tie up",    32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, F_INX);
    run("ovf",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, F_OVF | F_INX);
    run("inf-inf",   32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, F_INV);
    run("sub+sub",   32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, F_NONE);
    run("norm-sub",  32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF, F_NONE);
    run("2-1",       32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, F_NONE);
    run("1+(-3)",    32'h3F80_0000, 32'hC040_0000, 1'b0, 32'hC000_0000, F_NONE);
    run("inf-1",     32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, F_NONE);
    run("1-inf",     32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, F_NONE);
    run("nan",       32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, F_INV);

    // backpressure: hold out_ready low 10 cycles, result must stay put
    issue("hold", 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
    end
    chk("hold valid", 64'(out_valid), 64'd1);
    z0 = z;
    f0 = flags;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;  // ignored while busy
      if (!out_valid || in_ready || z !== z0 || flags !== f0) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("hold stable", 64'(stable), 64'd1);
    chk("hold z", 64'(z), 64'h4000_0000);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold release", 64'(out_valid), 64'd0);

    // reset while in ALIGN: everything back to idle at once
    issue("rst mid", 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    @(posedge clk);  // now in ALIGN
    #1;
    rst = 1'b0;
    #1;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stable = 1'b0;
    end
    chk("rst mid discarded", 64'(stable), 64'd1);

    // unit still usable after the reset
    run("post rst", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, F_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
